// File: rtl/gps_reg_pkg.sv
// gps_reg_pkg: shared widths, command record and state encodings for the register access path
package gps_reg_pkg;
    localparam int ADDR_W = 3;
    localparam int DATA_W = 8;
    localparam int CMD_READ_BIT = 7;
    localparam int ADDR_STATUS = 1;
    localparam int ADDR_ID = 7;
    localparam logic [7:0] ID_VALUE = 8'hBA;
    typedef struct packed {
        logic we;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
    } cmd_t;
    typedef enum logic {P_IDLE, P_HAVE_ADDR} parse_t;
    typedef enum logic {W_LOCAL, W_UART} src_t;
    typedef enum logic [1:0] {T_EMPTY, T_FULL, T_SENT, T_BUSY} txs_t;
endpackage

// File: rtl/reg_cmd_parser.sv
// reg_cmd_parser: turns the host byte stream into read/write commands, with an address-to-data timeout
module reg_cmd_parser
    import gps_reg_pkg::*;
#(
    parameter int CLKS_PER_BIT = 142,
    parameter int TIMEOUT_BYTES = 4
) (
    input  logic       clk_in,
    input  logic       rst_in,
    input  logic       rx_dv_in,
    input  logic [7:0] rx_byte_in,
    output logic       cmd_done,
    output cmd_t       cmd,
    output logic       timeout
);
    localparam int TMO = CLKS_PER_BIT * 10 * TIMEOUT_BYTES;
    localparam int CW = $clog2(TMO + 1);
    parse_t state, state_nx;
    logic [ADDR_W-1:0] addr_q;
    logic [CW-1:0] cnt;
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state <= P_IDLE;
            addr_q <= '0;
            cnt <= '0;
        end else begin
            state <= state_nx;
            if (rx_dv_in && state == P_IDLE && !rx_byte_in[CMD_READ_BIT]) begin
                addr_q <= rx_byte_in[ADDR_W-1:0];
                cnt <= CW'(TMO);
            end else if (cnt != '0) begin
                cnt <= cnt - CW'(1);
            end
        end
    end
    // In P_HAVE_ADDR any byte is data, even with the read bit set
    always_comb begin
        state_nx = state;
        cmd_done = 1'b0;
        timeout = 1'b0;
        cmd = '0;
        if (state == P_IDLE) begin
            cmd.addr = rx_byte_in[ADDR_W-1:0];
            if (rx_dv_in) begin
                cmd_done = rx_byte_in[CMD_READ_BIT];
                state_nx = rx_byte_in[CMD_READ_BIT] ? P_IDLE : P_HAVE_ADDR;
            end
        end else begin
            cmd.we = 1'b1;
            cmd.addr = addr_q;
            cmd.wdata = rx_byte_in;
            if (rx_dv_in) begin
                cmd_done = 1'b1;
                state_nx = P_IDLE;
            end else if (cnt == '0) begin
                timeout = 1'b1;
                state_nx = P_IDLE;
            end
        end
    end
endmodule

// File: rtl/reg_access_arb.sv
// reg_access_arb: round-robin register port arbiter between the UART host and a local requester,
// with a one-byte UART read response buffer and tx handshake
module reg_access_arb
    import gps_reg_pkg::*;
#(
    parameter int CLKS_PER_BIT = 142,
    parameter int TIMEOUT_BYTES = 4
) (
    input  logic              clk_in,
    input  logic              rst_in,
    input  logic              rx_dv_in,
    input  logic [7:0]        rx_byte_in,
    input  logic              tx_busy_in,
    output logic              tx_start_out,
    output logic [7:0]        tx_byte_out,
    input  logic              loc_req_in,
    input  logic              loc_we_in,
    input  logic [ADDR_W-1:0] loc_addr_in,
    input  logic [DATA_W-1:0] loc_wdata_in,
    output logic              loc_gnt_out,
    output logic              loc_rvalid_out,
    output logic [DATA_W-1:0] loc_rdata_out,
    output logic              reg_we_out,
    output logic              reg_re_out,
    output logic [ADDR_W-1:0] reg_addr_out,
    output logic [DATA_W-1:0] reg_wdata_out,
    input  logic [DATA_W-1:0] reg_rdata_in,
    output logic              proto_err_out
);
    cmd_t p_cmd, cmd_q;
    logic p_done, p_tmo, cmd_pending;
    src_t last_winner;
    txs_t ts, ts_nx;
    logic rd_uart, ret_v, ret_uart;
    logic [7:0] resp;
    logic uart_rd_busy, u_ok, pick_u, pick_l;

    reg_cmd_parser #(.CLKS_PER_BIT(CLKS_PER_BIT), .TIMEOUT_BYTES(TIMEOUT_BYTES)) u_parser (
        .clk_in(clk_in),
        .rst_in(rst_in),
        .rx_dv_in(rx_dv_in),
        .rx_byte_in(rx_byte_in),
        .cmd_done(p_done),
        .cmd(p_cmd),
        .timeout(p_tmo)
    );

    // A UART read in flight already owns the response buffer
    assign uart_rd_busy = ts != T_EMPTY || (reg_re_out && rd_uart) || (ret_v && ret_uart);
    assign u_ok = cmd_pending && (cmd_q.we || !uart_rd_busy);
    assign pick_u = !reg_re_out && u_ok && (!loc_req_in || last_winner == W_LOCAL);
    assign pick_l = !reg_re_out && loc_req_in && (!u_ok || last_winner == W_UART);
    assign tx_byte_out = resp;

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            reg_we_out <= 1'b0;
            reg_re_out <= 1'b0;
            reg_addr_out <= '0;
            reg_wdata_out <= '0;
            loc_gnt_out <= 1'b0;
            loc_rvalid_out <= 1'b0;
            loc_rdata_out <= '0;
            proto_err_out <= 1'b0;
            cmd_q <= '0;
            cmd_pending <= 1'b0;
            last_winner <= W_LOCAL;
            rd_uart <= 1'b0;
            ret_v <= 1'b0;
            ret_uart <= 1'b0;
            resp <= '0;
            ts <= T_EMPTY;
        end else begin
            reg_we_out <= pick_u ? cmd_q.we : pick_l && loc_we_in;
            reg_re_out <= pick_u ? !cmd_q.we : pick_l && !loc_we_in;
            reg_addr_out <= pick_u ? cmd_q.addr : pick_l ? loc_addr_in : '0;
            reg_wdata_out <= pick_u ? cmd_q.wdata : pick_l ? loc_wdata_in : '0;
            loc_gnt_out <= pick_l;
            rd_uart <= pick_u && !cmd_q.we;
            ret_v <= reg_re_out;
            ret_uart <= rd_uart;
            if (pick_u || pick_l)
                last_winner <= pick_u ? W_UART : W_LOCAL;
            // The pending slot is free again in the cycle its command is issued
            if (p_done && (!cmd_pending || pick_u)) begin
                cmd_q <= p_cmd;
                cmd_pending <= 1'b1;
            end else if (pick_u) begin
                cmd_pending <= 1'b0;
            end
            proto_err_out <= p_tmo || (p_done && cmd_pending && !pick_u);
            loc_rvalid_out <= ret_v && !ret_uart;
            if (ret_v && !ret_uart)
                loc_rdata_out <= reg_rdata_in;
            if (ret_v && ret_uart)
                resp <= reg_rdata_in;
            ts <= ts_nx;
        end
    end

    always_comb begin
        tx_start_out = ts == T_FULL && !tx_busy_in;
        ts_nx = (ts == T_EMPTY && ret_v && ret_uart) ? T_FULL :
                (ts == T_FULL && !tx_busy_in) ? T_SENT :
                (ts == T_SENT && tx_busy_in) ? T_BUSY :
                (ts == T_BUSY && !tx_busy_in) ? T_EMPTY : ts;
    end
endmodule

// File: tb/tb_reg_access_arb.sv
// tb_reg_access_arb: directed vector table plus hand sequences for ties, timeout, busy tx and reset
module tb_reg_access_arb;
    import gps_reg_pkg::*;
    logic test_clk_in = 1'b0;
    logic rst_in = 1'b1;
    logic rx_dv_in = 1'b0;
    logic [7:0] rx_byte_in = '0;
    logic tx_busy_in;
    logic force_busy = 1'b0;
    logic [2:0] txc = '0;
    logic tx_start_out;
    logic [7:0] tx_byte_out;
    logic loc_req_in = 1'b0;
    logic loc_we_in = 1'b0;
    logic [ADDR_W-1:0] loc_addr_in = '0;
    logic [DATA_W-1:0] loc_wdata_in = '0;
    logic loc_gnt_out, loc_rvalid_out, reg_we_out, reg_re_out, proto_err_out;
    logic [DATA_W-1:0] loc_rdata_out, reg_wdata_out;
    logic [DATA_W-1:0] reg_rdata_in = '0;
    logic [ADDR_W-1:0] reg_addr_out;
    int total = 0;
    int bad = 0;

    typedef struct {
        bit loc;
        bit two;
        logic [7:0] b0;
        logic [7:0] b1;
        bit we;
        logic [2:0] addr;
        logic [7:0] wdata;
        logic [7:0] rd;
    } vec_t;

    reg_access_arb dut (
        .clk_in(test_clk_in),
        .rst_in(rst_in),
        .rx_dv_in(rx_dv_in),
        .rx_byte_in(rx_byte_in),
        .tx_busy_in(tx_busy_in),
        .tx_start_out(tx_start_out),
        .tx_byte_out(tx_byte_out),
        .loc_req_in(loc_req_in),
        .loc_we_in(loc_we_in),
        .loc_addr_in(loc_addr_in),
        .loc_wdata_in(loc_wdata_in),
        .loc_gnt_out(loc_gnt_out),
        .loc_rvalid_out(loc_rvalid_out),
        .loc_rdata_out(loc_rdata_out),
        .reg_we_out(reg_we_out),
        .reg_re_out(reg_re_out),
        .reg_addr_out(reg_addr_out),
        .reg_wdata_out(reg_wdata_out),
        .reg_rdata_in(reg_rdata_in),
        .proto_err_out(proto_err_out)
    );

    always #5 test_clk_in = ~test_clk_in;

    function automatic logic [7:0] mem_val(input logic [2:0] a);
        return a == 3'd0 ? 8'h5A : a == 3'd7 ? 8'hBA : 8'hA0 + {5'd0, a};
    endfunction

    // Register file read port and a uart_tx stand-in that stays busy for 5 cycles per byte
    always @(posedge test_clk_in) begin
        if (reg_re_out) reg_rdata_in <= mem_val(reg_addr_out);
        txc <= rst_in ? 3'd0 : tx_start_out ? 3'd5 : txc != 3'd0 ? txc - 3'd1 : 3'd0;
    end
    assign tx_busy_in = force_busy | (txc != 3'd0);

    task automatic cyc();
        @(posedge test_clk_in);
        #1;
    endtask

    task automatic smp();
        @(negedge test_clk_in);
    endtask

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    function automatic logic [63:0] all_outs();
        return {31'd0, tx_start_out, tx_byte_out, loc_gnt_out, loc_rvalid_out, loc_rdata_out,
                reg_we_out, reg_re_out, reg_addr_out, reg_wdata_out, proto_err_out};
    endfunction

    initial begin
        vec_t vt[8];
        vec_t v;
        int lat, o, at, npulse, found;
        vt[0] = '{0, 1, 8'h05, 8'h3C, 1, 3'd5, 8'h3C, 8'h00};
        vt[1] = '{0, 0, 8'h87, 8'h00, 0, 3'd7, 8'h00, 8'hBA};
        vt[2] = '{0, 0, 8'hF9, 8'h00, 0, 3'd1, 8'h00, 8'hA1};
        vt[3] = '{0, 1, 8'h7F, 8'h80, 1, 3'd7, 8'h80, 8'h00};
        vt[4] = '{1, 0, 8'h00, 8'h00, 1, 3'd3, 8'hC4, 8'h00};
        vt[5] = '{1, 0, 8'h00, 8'h00, 0, 3'd6, 8'h00, 8'hA6};
        vt[6] = '{1, 0, 8'h00, 8'h00, 0, 3'd0, 8'h00, 8'h5A};
        vt[7] = '{0, 0, 8'h80, 8'h00, 0, 3'd0, 8'h00, 8'h5A};

        repeat (3) cyc();
        smp();
        chk("reset_outs", all_outs(), 0);
        cyc();
        rst_in = 1'b0;
        smp();
        chk("post_reset_outs", all_outs(), 0);
        repeat (2) cyc();

        for (int i = 0; i < 8; i++) begin
            v = vt[i];
            if (!v.loc) begin
                if (v.two) begin
                    cyc();
                    rx_dv_in = 1'b1;
                    rx_byte_in = v.b0;
                end
                cyc();
                rx_dv_in = 1'b1;
                rx_byte_in = v.two ? v.b1 : v.b0;
                lat = 2;
            end else begin
                cyc();
                loc_req_in = 1'b1;
                loc_we_in = v.we;
                loc_addr_in = v.addr;
                loc_wdata_in = v.wdata;
                lat = 1;
            end
            for (int k = 1; k <= lat + 3; k++) begin
                cyc();
                rx_dv_in = 1'b0;
                if (v.loc && k == 1) loc_req_in = 1'b0;
                smp();
                o = k - lat;
                chk($sformatf("v%0d_we_o%0d", i, o), reg_we_out, o == 0 && v.we);
                chk($sformatf("v%0d_re_o%0d", i, o), reg_re_out, o == 0 && !v.we);
                chk($sformatf("v%0d_gnt_o%0d", i, o), loc_gnt_out, o == 0 && v.loc);
                chk($sformatf("v%0d_rvalid_o%0d", i, o), loc_rvalid_out, o == 2 && v.loc && !v.we);
                chk($sformatf("v%0d_txstart_o%0d", i, o), tx_start_out, o == 2 && !v.loc && !v.we);
                chk($sformatf("v%0d_err_o%0d", i, o), proto_err_out, 0);
                if (o == 0) chk($sformatf("v%0d_addr", i), reg_addr_out, v.addr);
                if (o == 0 && v.we) chk($sformatf("v%0d_wdata", i), reg_wdata_out, v.wdata);
                if (o == 2 && !v.we) chk($sformatf("v%0d_rdata", i), v.loc ? loc_rdata_out : tx_byte_out, v.rd);
            end
            repeat (10) cyc();
        end

        // Tie sequence: fresh reset so UART wins the first tie, local the second
        rst_in = 1'b1;
        cyc();
        rst_in = 1'b0;
        cyc();
        rx_dv_in = 1'b1;
        rx_byte_in = 8'h02;
        cyc();
        rx_byte_in = 8'h55;
        cyc();
        rx_byte_in = 8'h83;
        loc_req_in = 1'b1;
        loc_we_in = 1'b0;
        loc_addr_in = 3'd4;
        smp();
        chk("tie_c2_nostrobe", {reg_we_out, reg_re_out}, 0);
        cyc();
        rx_dv_in = 1'b0;
        smp();
        chk("tie1_uart_we", reg_we_out, 1);
        chk("tie1_uart_addr", reg_addr_out, 2);
        chk("tie1_uart_wdata", reg_wdata_out, 8'h55);
        chk("tie1_no_gnt", loc_gnt_out, 0);
        cyc();
        loc_req_in = 1'b0;
        smp();
        chk("tie2_loc_gnt", loc_gnt_out, 1);
        chk("tie2_loc_re", reg_re_out, 1);
        chk("tie2_loc_addr", reg_addr_out, 4);
        cyc();
        smp();
        chk("tie_c5_nostrobe", {reg_we_out, reg_re_out}, 0);
        cyc();
        smp();
        chk("tie_uart_rd_re", reg_re_out, 1);
        chk("tie_uart_rd_addr", reg_addr_out, 3);
        chk("tie_loc_rvalid", loc_rvalid_out, 1);
        chk("tie_loc_rdata", loc_rdata_out, 8'hA4);
        cyc();
        smp();
        chk("tie_c7_notx", tx_start_out, 0);
        cyc();
        smp();
        chk("tie_uart_txstart", tx_start_out, 1);
        chk("tie_uart_txbyte", tx_byte_out, 8'hA3);
        repeat (10) cyc();

        // Address byte followed by silence must time out; next byte is an address again
        rx_dv_in = 1'b1;
        rx_byte_in = 8'h03;
        at = -1;
        npulse = 0;
        for (int k = 1; k <= 5700; k++) begin
            cyc();
            rx_dv_in = 1'b0;
            smp();
            if (proto_err_out) begin
                if (at < 0) at = k;
                npulse++;
            end
        end
        chk("tmo_pulses", npulse, 1);
        chk("tmo_window", at >= 5680 && at <= 5684, 1);
        cyc();
        rx_dv_in = 1'b1;
        rx_byte_in = 8'h11;
        for (int k = 1; k <= 3; k++) begin
            cyc();
            rx_dv_in = 1'b0;
            smp();
            chk($sformatf("tmo_addr_nostrobe_%0d", k), {reg_we_out, reg_re_out}, 0);
        end
        cyc();
        rx_dv_in = 1'b1;
        rx_byte_in = 8'h22;
        cyc();
        rx_dv_in = 1'b0;
        cyc();
        smp();
        chk("tmo_after_we", reg_we_out, 1);
        chk("tmo_after_addr", reg_addr_out, 1);
        chk("tmo_after_wdata", reg_wdata_out, 8'h22);
        repeat (5) cyc();

        // Busy transmitter: first read waits for busy low, second read waits for the buffer
        force_busy = 1'b1;
        rx_dv_in = 1'b1;
        rx_byte_in = 8'h80;
        cyc();
        rx_dv_in = 1'b0;
        cyc();
        smp();
        chk("busy_rd1_re", reg_re_out, 1);
        chk("busy_rd1_addr", reg_addr_out, 0);
        cyc();
        rx_dv_in = 1'b1;
        rx_byte_in = 8'h81;
        found = 0;
        for (int k = 0; k < 12; k++) begin
            cyc();
            rx_dv_in = 1'b0;
            smp();
            if (tx_start_out || reg_re_out || reg_we_out) found++;
        end
        chk("busy_held_off", found, 0);
        cyc();
        force_busy = 1'b0;
        smp();
        chk("busy_rd1_txstart", tx_start_out, 1);
        chk("busy_rd1_txbyte", tx_byte_out, 8'h5A);
        found = -1;
        for (int k = 1; k <= 30 && found < 0; k++) begin
            cyc();
            smp();
            if (reg_re_out) begin
                found = k;
                chk("busy_rd2_addr", reg_addr_out, 1);
            end
        end
        chk("busy_rd2_after_tx", found >= 7 && found <= 10, 1);
        found = 0;
        for (int k = 1; k <= 10 && found == 0; k++) begin
            cyc();
            smp();
            if (tx_start_out) begin
                found = 1;
                chk("busy_rd2_txbyte", tx_byte_out, 8'hA1);
            end
        end
        chk("busy_rd2_txstart", found, 1);
        repeat (10) cyc();

        // Reset on the read strobe cycle aborts the return, UART then local
        for (int s = 0; s < 2; s++) begin
            if (s == 0) begin
                rx_dv_in = 1'b1;
                rx_byte_in = 8'h87;
                cyc();
                rx_dv_in = 1'b0;
                cyc();
            end else begin
                loc_req_in = 1'b1;
                loc_we_in = 1'b0;
                loc_addr_in = 3'd5;
                cyc();
                loc_req_in = 1'b0;
            end
            rst_in = 1'b1;
            smp();
            chk($sformatf("rst%0d_strobe", s), reg_re_out, 1);
            cyc();
            rst_in = 1'b0;
            smp();
            chk($sformatf("rst%0d_outs", s), all_outs(), 0);
            found = 0;
            for (int k = 0; k < 6; k++) begin
                cyc();
                smp();
                if (tx_start_out || loc_rvalid_out || reg_re_out) found++;
            end
            chk($sformatf("rst%0d_no_return", s), found, 0);
            cyc();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
